dual_issue_ctrl: RTL and testbench
==================================

// Module: dual_issue_ctrl
// PURPOSE
// - In-order dual-issue stage directly downstream of the instruction FIFO.
// - Takes up to 2 oldest inst_t entries per cycle and checks RAW hazards against a per-register scoreboard.
// - Returns the number consumed to the FIFO; registers the issued pair into the execute-stage input register.
// PARAMETERS
// - SB_CNT_W  2  width of each per-register in-flight write counter (max 2^SB_CNT_W-1 pending writes)
// - WB_PORTS  2  number of writeback release ports
// PORTS
// - clk             in   1              clock
// - rst_n           in   1              asynchronous active-low reset
// - inst_i          in   inst_t[1:0]    FIFO head entries; [0] is oldest
// - inst_valid_i    in   2              per-slot valid from FIFO
// - issue_num_o     out  2              entries consumed this cycle (0/1/2)
// - backend_stall_o out  1              FIFO read not ready (= ~ex_ready_i | flush_i)
// - flush_i         in   1              pipeline flush from commit
// - ex_ready_i      in   1              execute stage accepts the output register this cycle
// - ex_inst_o       out  inst_t[1:0]    registered issued pair
// - ex_valid_o      out  2              per-slot valid of ex_inst_o
// - wb_valid_i      in   WB_PORTS       writeback release strobes
// - wb_reg_i        in   5*WB_PORTS     released destination registers
// - perf_dual_o     out  32             cycles with 2 issued (ISSUE_PERF_CNT_EN)
// - perf_single_o   out  32             cycles with 1 issued
// - perf_stall_o    out  32             cycles with valid slot0 but 0 issued
// BEHAVIOUR
// Reset
// - ex_valid_o=0, ex_inst_o=0, scoreboard counters all 0, perf counters 0.
// - issue_num_o/backend_stall_o are combinational.
// Pending definition
// - pend(r) = (cnt[r]!=0) && r!=0. Register 0 is never pending and never counted.
// Slot 0 issue (iss0)
// - Requires inst_valid_i[0], ex_ready_i, !flush_i.
// - Requires !pend(r_reg[0]) and !pend(r_reg[1]).
// - Requires cnt[w_reg] not saturated (cnt[w_reg] != max) when w_reg!=0.
// Slot 1 issue (iss1)
// - Requires iss0, inst_valid_i[1], and the same pending/saturation checks.
// - Neither r_reg of slot1 equals slot0.w_reg when that is nonzero (intra-pair RAW).
// - If both slots write the same nonzero reg, that counter must be <= max-2.
// Outputs
// - issue_num_o = iss0 + iss1; never 2'b11.
// Output register
// - Loads when ex_ready_i: ex_inst_o <= inst_i, ex_valid_o <= {iss1, iss0}; unissued slots become bubbles.
// - Holds when !ex_ready_i.
// - Single-cycle latency from FIFO head to ex_*_o.
// Scoreboard update, per register each cycle
// - cnt += (#issued slots writing r) - (#wb ports releasing r); both can occur in the same cycle, net applied.
// - A release on r=0 or on a counter already at 0 is ignored (no underflow).
// - A writeback releasing r in cycle N allows a reader of r to issue in cycle N+1, not N (no bypass through scoreboard).
// Flush
// - flush_i: ex_valid_o <= 0, all counters <= 0, wb_* ignored that cycle, issue_num_o=0.
// - Commit asserts flush_i only after all older writes have retired, so clearing is safe.
// - flush_i has priority over every other event.
// Empty / partial FIFO
// - inst_valid_i=2'b00 -> issue_num_o=0 and a bubble is loaded if ex_ready_i.
// - inst_valid_i=2'b10 is illegal (FIFO is compacted).
// CONFIGURATION
// - ISSUE_PERF_CNT_EN defined: three 32-bit wrapping counters increment per the PORTS definitions; cleared only by rst_n (not by flush_i); counting is suppressed in cycles where ex_ready_i=0.
// - ISSUE_PERF_CNT_EN undefined: no counter flops; perf_*_o tied to 0.
// TESTING
// - Independent pair (r4<-r1+r2, r5<-r1+r3), ex_ready_i=1 -> issue_num_o=2, next cycle ex_valid_o=2'b11, cnt[4]=cnt[5]=1.
// - Intra-pair RAW (r4<-r1+r2, r6<-r4+r1) -> issue_num_o=1, ex_valid_o=2'b01; slot1 issues next cycle only after wb of r4.
// - Pending r7; wb_valid_i[0]=1, wb_reg_i=7 in cycle N with reader at head -> issue_num_o=0 in N, 1 in N+1.
// - Same-cycle issue writing r9 and wb release of r9 with cnt[9]=1 -> cnt[9] stays 1; wb of r0 leaves state unchanged.
// - Three writers to r3 back-to-back without wb (SB_CNT_W=2) -> first 3 issue, 4th stalls at cnt=3 until a release.
// - ex_ready_i=0 for 3 cycles -> backend_stall_o=1, issue_num_o=0, ex_* held; flush_i mid-run -> ex_valid_o=0, all cnt=0 next cycle.

Source files
------------

// File: rtl/dual_issue_ctrl.sv
// In-order dual-issue stage: RAW/saturation checks against a per-register scoreboard, registered issue pair.
// Optional build macro ISSUE_PERF_CNT_EN adds dual/single/stall performance counters.
package dual_issue_ctrl_pkg;
    typedef struct packed {
        logic [7:0]      tag;
        logic [4:0]      w_reg;
        logic [1:0][4:0] r_reg;
    } inst_t;
endpackage

module dual_issue_ctrl
    import dual_issue_ctrl_pkg::*;
#(
    parameter int SB_CNT_W = 2,
    parameter int WB_PORTS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  inst_t [1:0]           inst_i,
    input  logic  [1:0]           inst_valid_i,
    output logic  [1:0]           issue_num_o,
    output logic                  backend_stall_o,
    input  logic                  flush_i,
    input  logic                  ex_ready_i,
    output inst_t [1:0]           ex_inst_o,
    output logic  [1:0]           ex_valid_o,
    input  logic  [WB_PORTS-1:0]  wb_valid_i,
    input  logic  [5*WB_PORTS-1:0] wb_reg_i,
    output logic  [31:0]          perf_dual_o,
    output logic  [31:0]          perf_single_o,
    output logic  [31:0]          perf_stall_o
);
    localparam logic [SB_CNT_W-1:0] CNT_MAX  = '1;
    localparam int                  PAIR_LIM = (2 ** SB_CNT_W) - 3;

    logic [SB_CNT_W-1:0] r_cnt     [32];
    logic [SB_CNT_W-1:0] w_cnt_nxt [32];
    logic [31:0]         w_pend;
    logic [31:0]         w_sat;
    logic [31:0]         w_near;
    logic                w_iss0;
    logic                w_iss1;
    logic                w_raw1;
    logic                w_waw1;

    // Register 0 is hardwired: never pending, never saturated, never counted.
    always_comb begin
        w_pend = '0;
        w_sat  = '0;
        w_near = '0;
        for (int r = 1; r < 32; r++) begin
            w_pend[r] = (r_cnt[r] != '0);
            w_sat[r]  = (r_cnt[r] == CNT_MAX);
            w_near[r] = (int'(r_cnt[r]) > PAIR_LIM);
        end
    end

    always_comb begin
        w_iss0 = inst_valid_i[0] && ex_ready_i && !flush_i
              && !w_pend[inst_i[0].r_reg[0]] && !w_pend[inst_i[0].r_reg[1]]
              && !w_sat[inst_i[0].w_reg];
        w_raw1 = (inst_i[0].w_reg != 5'd0)
              && ((inst_i[1].r_reg[0] == inst_i[0].w_reg) || (inst_i[1].r_reg[1] == inst_i[0].w_reg));
        w_waw1 = (inst_i[1].w_reg != 5'd0) && (inst_i[1].w_reg == inst_i[0].w_reg)
              && w_near[inst_i[1].w_reg];
        w_iss1 = w_iss0 && inst_valid_i[1]
              && !w_pend[inst_i[1].r_reg[0]] && !w_pend[inst_i[1].r_reg[1]]
              && !w_sat[inst_i[1].w_reg] && !w_raw1 && !w_waw1;
    end

    assign issue_num_o     = w_iss1 ? 2'd2 : (w_iss0 ? 2'd1 : 2'd0);
    assign backend_stall_o = !ex_ready_i || flush_i;

    // Net update per register; releases are capped at the current count so spurious ones cannot underflow.
    always_comb begin
        int v_inc;
        int v_dec;
        v_inc = 0;
        v_dec = 0;
        w_cnt_nxt[0] = '0;
        for (int r = 1; r < 32; r++) begin
            v_inc = 0;
            v_dec = 0;
            if (w_iss0 && inst_i[0].w_reg == 5'(r)) v_inc = v_inc + 1;
            if (w_iss1 && inst_i[1].w_reg == 5'(r)) v_inc = v_inc + 1;
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid_i[p] && wb_reg_i[5*p +: 5] == 5'(r)) v_dec = v_dec + 1;
            end
            if (v_dec > int'(r_cnt[r])) v_dec = int'(r_cnt[r]);
            w_cnt_nxt[r] = SB_CNT_W'(int'(r_cnt[r]) + v_inc - v_dec);
        end
    end

    // NOTE: the scoreboard array is reset explicitly; stale counts after reset would block issue forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) r_cnt[r] <= '0;
            ex_inst_o  <= '0;
            ex_valid_o <= '0;
        end else begin
            if (ex_ready_i) ex_inst_o <= inst_i;
            if (flush_i) begin
                for (int r = 0; r < 32; r++) r_cnt[r] <= '0;
                ex_valid_o <= '0;
            end else begin
                for (int r = 0; r < 32; r++) r_cnt[r] <= w_cnt_nxt[r];
                if (ex_ready_i) ex_valid_o <= {w_iss1, w_iss0};
            end
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] r_perf_dual;
    logic [31:0] r_perf_single;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_dual   <= '0;
            r_perf_single <= '0;
            r_perf_stall  <= '0;
        end else if (ex_ready_i) begin
            if (w_iss1) r_perf_dual <= r_perf_dual + 32'd1;
            if (w_iss0 && !w_iss1) r_perf_single <= r_perf_single + 32'd1;
            if (inst_valid_i[0] && !w_iss0) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_dual_o   = r_perf_dual;
    assign perf_single_o = r_perf_single;
    assign perf_stall_o  = r_perf_stall;
`else
    assign perf_dual_o   = '0;
    assign perf_single_o = '0;
    assign perf_stall_o  = '0;
`endif
endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Self-checking bench for dual_issue_ctrl: directed hazard scenarios plus randomized traffic
// compared against a per-register pending-count reference model.
module tb_dual_issue_ctrl;
    import dual_issue_ctrl_pkg::*;

    localparam int SB_CNT_W = 2;
    localparam int WB_PORTS = 2;
    localparam int MAXC     = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    inst_t [1:0] inst_i = '0;
    logic  [1:0] inst_valid_i = '0;
    logic  [1:0] issue_num_o;
    logic        backend_stall_o;
    logic        flush_i = 1'b0;
    logic        ex_ready_i = 1'b0;
    inst_t [1:0] ex_inst_o;
    logic  [1:0] ex_valid_o;
    logic  [1:0] wb_valid_i = '0;
    logic  [9:0] wb_reg_i = '0;
    logic [31:0] perf_dual_o, perf_single_o, perf_stall_o;

    dual_issue_ctrl #(.SB_CNT_W(SB_CNT_W), .WB_PORTS(WB_PORTS)) dut (
        .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
        .issue_num_o(issue_num_o), .backend_stall_o(backend_stall_o), .flush_i(flush_i),
        .ex_ready_i(ex_ready_i), .ex_inst_o(ex_inst_o), .ex_valid_o(ex_valid_o),
        .wb_valid_i(wb_valid_i), .wb_reg_i(wb_reg_i), .perf_dual_o(perf_dual_o),
        .perf_single_o(perf_single_o), .perf_stall_o(perf_stall_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: outstanding writes per register, expected output register and perf counts.
    int          m_cnt [32];
    inst_t [1:0] m_ex_inst = '0;
    logic  [1:0] m_ex_valid = '0;
    logic [31:0] m_dual = '0, m_single = '0, m_stall = '0;

    function automatic inst_t mk(input int tag, input int w, input int a, input int b);
        inst_t t;
        t.tag      = 8'(tag);
        t.w_reg    = 5'(w);
        t.r_reg[0] = 5'(a);
        t.r_reg[1] = 5'(b);
        return t;
    endfunction

    // Issue in order; a slot stalls if a source has outstanding writes (older or earlier in this pair)
    // or if its destination would exceed the counter capacity.
    function automatic int model_issue(input inst_t [1:0] ins, input logic [1:0] v,
                                       input logic rdy, input logic fl);
        int n = 0;
        int pw [32];
        for (int r = 0; r < 32; r++) pw[r] = 0;
        if (!rdy || fl) return 0;
        for (int s = 0; s < 2; s++) begin
            int w;
            bit blocked = 0;
            if (!v[s]) break;
            for (int k = 0; k < 2; k++) begin
                int rr = int'(ins[s].r_reg[k]);
                if (rr != 0 && (m_cnt[rr] > 0 || pw[rr] > 0)) blocked = 1;
            end
            w = int'(ins[s].w_reg);
            if (w != 0 && m_cnt[w] + pw[w] >= MAXC) blocked = 1;
            if (blocked) break;
            n++;
            if (w != 0) pw[w]++;
        end
        return n;
    endfunction

    task automatic check_regs();
        check("ex_valid", 64'(ex_valid_o), 64'(m_ex_valid));
        check("ex_inst", 64'(ex_inst_o), 64'(m_ex_inst));
        check("perf_dual", 64'(perf_dual_o), 64'(m_dual));
        check("perf_single", 64'(perf_single_o), 64'(m_single));
        check("perf_stall", 64'(perf_stall_o), 64'(m_stall));
    endtask

    // One cycle: check registered state, drive inputs, check combinational outputs, advance the model.
    task automatic step(input inst_t [1:0] ins, input logic [1:0] v, input logic rdy,
                        input logic fl, input logic [1:0] wbv, input logic [9:0] wbr);
        int n;
        int rel [32];
        @(negedge clk);
        check_regs();
        inst_i = ins; inst_valid_i = v; ex_ready_i = rdy; flush_i = fl;
        wb_valid_i = wbv; wb_reg_i = wbr;
        #1;
        n = model_issue(ins, v, rdy, fl);
        check("issue_num", 64'(issue_num_o), 64'(n));
        check("backend_stall", 64'(backend_stall_o), 64'(!rdy || fl));
`ifdef ISSUE_PERF_CNT_EN
        if (rdy) begin
            if (n == 2) m_dual++;
            if (n == 1) m_single++;
            if (v[0] && n == 0) m_stall++;
        end
`endif
        if (rdy) m_ex_inst = ins;
        if (fl) begin
            m_ex_valid = '0;
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        end else begin
            for (int r = 0; r < 32; r++) rel[r] = 0;
            for (int p = 0; p < WB_PORTS; p++) if (wbv[p]) rel[int'(wbr[5*p +: 5])]++;
            for (int r = 1; r < 32; r++) m_cnt[r] -= (rel[r] < m_cnt[r]) ? rel[r] : m_cnt[r];
            for (int s = 0; s < n; s++) if (ins[s].w_reg != 0) m_cnt[int'(ins[s].w_reg)]++;
            if (rdy) m_ex_valid = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
        end
    endtask

    task automatic idle(input logic [1:0] wbv, input logic [9:0] wbr);
        step('0, 2'b00, 1'b1, 1'b0, wbv, wbr);
    endtask

    task automatic do_flush();
        step('0, 2'b00, 1'b1, 1'b1, 2'b00, '0);
    endtask

    inst_t [1:0] pr;

    initial begin
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        repeat (2) @(negedge clk);
        check_regs();
        rst_n = 1'b1;

        // Independent pair, then a reader of r4 blocked by the new pending write.
        pr = {mk(2, 5, 1, 3), mk(1, 4, 1, 2)};
        step(pr, 2'b11, 1'b1, 1'b0, 2'b00, '0);
        check("dir_pair_num", 64'(issue_num_o), 64'd2);
        step({mk(0, 0, 0, 0), mk(3, 6, 4, 0)}, 2'b01, 1'b1, 1'b0, 2'b00, '0);
        check("dir_pair_valid", 64'(ex_valid_o), 64'b11);
        check("dir_pend_r4", 64'(issue_num_o), 64'd0);
        do_flush();

        // Intra-pair RAW; release of r4 in cycle N lets the reader go only in N+1.
        pr = {mk(5, 6, 4, 1), mk(4, 4, 1, 2)};
        step(pr, 2'b11, 1'b1, 1'b0, 2'b00, '0);
        check("dir_raw_num", 64'(issue_num_o), 64'd1);
        pr = {mk(0, 0, 0, 0), mk(5, 6, 4, 1)};
        step(pr, 2'b01, 1'b1, 1'b0, 2'b01, 10'd4);
        check("dir_raw_valid", 64'(ex_valid_o), 64'b01);
        check("dir_wb_same_cycle", 64'(issue_num_o), 64'd0);
        step(pr, 2'b01, 1'b1, 1'b0, 2'b00, '0);
        check("dir_wb_next_cycle", 64'(issue_num_o), 64'd1);
        do_flush();

        // Issue and release of r9 in the same cycle keeps the count; r0 release is harmless.
        step({mk(0, 0, 0, 0), mk(7, 9, 0, 0)}, 2'b01, 1'b1, 1'b0, 2'b00, '0);
        step({mk(0, 0, 0, 0), mk(8, 9, 0, 0)}, 2'b01, 1'b1, 1'b0, 2'b11, {5'd0, 5'd9});
        pr = {mk(0, 0, 0, 0), mk(9, 1, 9, 0)};
        step(pr, 2'b01, 1'b1, 1'b0, 2'b01, 10'd9);
        check("dir_r9_still_pend", 64'(issue_num_o), 64'd0);
        step(pr, 2'b01, 1'b1, 1'b0, 2'b00, '0);
        check("dir_r9_free", 64'(issue_num_o), 64'd1);
        do_flush();

        // Saturation: three writers of r3 go, the fourth waits for a release.
        for (int i = 0; i < 3; i++) step({mk(0, 0, 0, 0), mk(10 + i, 3, 0, 0)}, 2'b01, 1'b1, 1'b0, 2'b00, '0);
        pr = {mk(0, 0, 0, 0), mk(13, 3, 0, 0)};
        step(pr, 2'b01, 1'b1, 1'b0, 2'b00, '0);
        check("dir_sat_stall", 64'(issue_num_o), 64'd0);
        step(pr, 2'b01, 1'b1, 1'b0, 2'b10, {5'd3, 5'd0});
        check("dir_sat_wb_cycle", 64'(issue_num_o), 64'd0);
        step(pr, 2'b01, 1'b1, 1'b0, 2'b00, '0);
        check("dir_sat_release", 64'(issue_num_o), 64'd1);

        // Backpressure holds the output register, then a flush mid-run.
        for (int i = 0; i < 3; i++) begin
            step({mk(21, 2, 0, 0), mk(20, 1, 0, 0)}, 2'b11, 1'b0, 1'b0, 2'b00, '0);
            check("dir_bp_stall", 64'(backend_stall_o), 64'd1);
            check("dir_bp_num", 64'(issue_num_o), 64'd0);
        end
        step({mk(23, 8, 0, 0), mk(22, 7, 0, 0)}, 2'b11, 1'b1, 1'b1, 2'b00, '0);
        check("dir_flush_num", 64'(issue_num_o), 64'd0);
        step({mk(25, 0, 3, 0), mk(24, 0, 3, 0)}, 2'b11, 1'b1, 1'b0, 2'b00, '0);
        check("dir_flush_valid", 64'(ex_valid_o), 64'b00);
        check("dir_flush_cnt_clear", 64'(issue_num_o), 64'd2);

        // Randomized traffic over a small register pool so hazards are frequent.
        for (int c = 0; c < 3000; c++) begin
            inst_t [1:0] ri;
            logic  [1:0] rv, wbv;
            logic  [9:0] wbr;
            int pend [$];
            for (int s = 0; s < 2; s++)
                ri[s] = mk($urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       rv = 2'b00;
                1:       rv = 2'b01;
                default: rv = 2'b11;
            endcase
            for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) pend.push_back(r);
            wbv = '0;
            wbr = '0;
            for (int p = 0; p < WB_PORTS; p++) begin
                wbv[p] = ($urandom_range(0, 1) == 1);
                if (pend.size() > 0 && $urandom_range(0, 7) != 0)
                    wbr[5*p +: 5] = 5'(pend[$urandom_range(0, pend.size() - 1)]);
            end
            step(ri, rv, $urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0, wbv, wbr);
        end

        @(negedge clk);
        check_regs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
